uart_rx_capture: RTL
====================

// Module: uart_rx_capture
// PURPOSE
//  Synthesizable 8N1 UART receiver with receive FIFO. Consumes the SoC uart_tx pad output.
//  Gives on-FPGA/silicon captures the same role the behavioural UART bus model has in simulation.
//  Delivers received bytes on a valid/ready stream to the host-side logic (debug bridge/LEDs).
// PARAMETERS
//  CLK_FREQ_HZ  25_000_000  system clock frequency
//  BAUD_RATE    781250      line rate; DIV = CLK_FREQ_HZ/BAUD_RATE (=32), elaboration error if DIV<4
//  FIFO_DEPTH   8           receive FIFO entries, power of two >=2
// PORTS
//  clk          in   1                 system clock
//  rst_n        in   1                 asynchronous active-low reset
//  rx_i         in   1                 serial line from SoC uart_tx; idle high, asynchronous
//  rx_en_i      in   1                 receiver enable
//  data_o       out  8                 head-of-FIFO byte (first-word-fall-through)
//  valid_o      out  1                 FIFO non-empty
//  ready_i      in   1                 pop when valid_o&&ready_i
//  frame_err_o  out  1                 1-cycle pulse: stop bit (or parity) wrong
//  overflow_o   out  1                 1-cycle pulse: byte dropped, FIFO full
//  count_o      out  $clog2(DEPTH)+1   FIFO occupancy
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops and edge-detect reg =1; FSM IDLE; FIFO empty.
//  - rx_i passes a 2-flop synchronizer (reset 1); all FSM decisions use the synced value rxs.
//  - FSM IDLE: falling edge of rxs with rx_en_i=1 -> START, bitcnt cleared.
//  - FSM START: at cycle DIV/2-1 sample; rxs=1 -> IDLE (glitch, no error); rxs=0 -> DATA.
//  - FSM DATA: sample every DIV cycles, shift in LSB first; after 8th sample -> STOP (or PARITY).
//  - FSM STOP: sample after DIV cycles; 1 -> push byte; 0 -> frame_err_o pulse, byte discarded.
//    Either way -> IDLE same cycle; a new start needs a fresh falling edge.
//  - Latency: byte appears on data_o/valid_o the cycle after the stop sample
//    (DIV/2+9*DIV+3 cycles after rx_i falls, incl. synchronizer).
//  - FIFO: push when full and no pop same cycle -> byte dropped, overflow_o pulse, contents intact.
//    Push+pop same cycle when full -> both succeed, count unchanged.
//    Pop when empty -> ignored. Pointers wrap modulo FIFO_DEPTH.
//  - rx_en_i low mid-frame -> IDLE next cycle, partial byte discarded, no error; FIFO unaffected.
//  - Async reset mid-frame clears FSM and FIFO immediately; no pulses on release.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state between DATA and STOP samples an even-parity bit.
//    Mismatch -> frame_err_o pulse, byte discarded (STOP still traversed). Frame is 11 bits.
//  Undefined: no PARITY state, 10-bit frame, no parity check logic.
// STRUCTURE
//  - uart_rx_pkg holds:
//    - rx_state_e enum {IDLE,START,DATA,PARITY,STOP}
//    - function calc_div(clk,baud)
//    - localparam DATA_BITS=8
//  - Sub-module uart_rx_fifo (DEPTH param; push/pop/full/empty/count; FWFT) is instantiated once.
//  - Sampler FSM, bit counter and baud counter stay in uart_rx_capture.
// TESTING (DIV=32, FIFO_DEPTH=8)
//  1. Drive 0xA5 8N1, ready_i=1 -> valid_o 1 cycle with data_o=0xA5; no error pulses.
//  2. 8-cycle low glitch on rx_i -> FSM back in IDLE, valid_o stays 0, frame_err_o stays 0.
//  3. Send 0x3C with stop bit 0 -> frame_err_o one pulse, count_o=0.
//     Next valid frame 0x11 is received correctly.
//  4. ready_i=0, send 0x00..0x08 -> count_o=8, one overflow_o pulse on 9th byte.
//     With ready_i=1, pops return 0x00..0x07 in order.
//  5. Assert rst_n=0 at bit 4 of a frame -> outputs 0; next frame 0x5A received correctly.
//  6. With UART_RX_PARITY_EN, send 0x07 with parity 0 -> frame_err_o pulse, no push.
//     Same byte with parity 1 -> data_o=0x07.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART capture receiver.
// Optional even-parity support is selected with UART_RX_PARITY_EN.
package uart_rx_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   // Clocks per bit period.
   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO. Pops on empty are ignored. A push
// while full only succeeds when a pop happens in the same cycle.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [W-1:0]             data_i,
   input  logic                     pop_i,
   output logic [W-1:0]             data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]             cnt_q, cnt_d;
   logic                    do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Next-state for storage, pointers (wrap naturally, DEPTH is 2^n) and occupancy.
   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wr_q] = data_i;
      wr_d  = wr_q + AW'(do_push);
      rd_d  = rd_q + AW'(do_pop);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   // State registers; storage is cleared so data_o reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver feeding a FWFT receive FIFO with a valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_capture
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 25_000_000,
   parameter int BAUD_RATE   = 781250,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx_i,
   input  logic                          rx_en_i,
   output logic [7:0]                    data_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic                          frame_err_o,
   output logic                          overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o
);
   localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);
   localparam int CW  = $clog2(DIV);

   if (DIV < 4) begin : g_div_chk
      $error("uart_rx_capture: CLK_FREQ_HZ/BAUD_RATE must be >= 4");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_rx_capture: FIFO_DEPTH must be a power of two >= 2");
   end

   localparam logic [CW-1:0] HALF = CW'(DIV/2 - 1);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   rx_state_e      state_q, state_d;
   logic [1:0]     sync_q;
   logic           prev_q;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     bitcnt_q, bitcnt_d;
   logic [7:0]     shift_q, shift_d;
   logic           ferr_q, ferr_d;
   logic           ovf_q, ovf_d;
   logic           push;
   logic           full, empty;
   logic           rxs, fall;
`ifdef UART_RX_PARITY_EN
   logic           perr_q, perr_d;
`endif

   assign rxs  = sync_q[1];
   assign fall = prev_q && !rxs;

   // Two-flop synchronizer plus edge-detect register; all idle high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], rx_i};
         prev_q <= rxs;
      end
   end

   // Sampler: start is checked at mid-bit, then one sample per bit period.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      ferr_d   = 1'b0;
      push     = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d   = perr_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall && rx_en_i) begin
               state_d  = START;
               bitcnt_d = '0;
            end
         end
         START: if (cnt_q == HALF) begin
            cnt_d   = '0;
            state_d = rxs ? IDLE : DATA;
         end
         DATA: if (cnt_q == LAST) begin
            cnt_d    = '0;
            shift_d  = {rxs, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (cnt_q == LAST) begin
            cnt_d   = '0;
            perr_d  = rxs ^ (^shift_q);
            state_d = STOP;
         end
`endif
         STOP: if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (rxs && !perr_q) push = 1'b1;
`else
            if (rxs) push = 1'b1;
`endif
            else ferr_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // Disabling drops any partial frame silently.
      if (!rx_en_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         push    = 1'b0;
         ferr_d  = 1'b0;
      end
   end

   // A push that finds the FIFO full with no simultaneous pop is dropped.
   assign ovf_d = push && full && !(ready_i && !empty);

   // Sampler and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bitcnt_q <= '0;
         shift_q  <= '0;
         ferr_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         ferr_q   <= ferr_d;
         ovf_q    <= ovf_d;
`ifdef UART_RX_PARITY_EN
         perr_q   <= perr_d;
`endif
      end
   end

   uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (shift_q),
      .pop_i   (ready_i),
      .data_o  (data_o),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count_o)
   );

   assign valid_o     = !empty;
   assign frame_err_o = ferr_q;
   assign overflow_o  = ovf_q;

endmodule
